muldiv_unit: RTL and testbench

Iterative multiply/divide execution unit with architectural HI/LO registers. Operands are the two register-file read ports (busA/busB). It executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle latency and holds results in HI/LO for MFHI/MFLO. The unit raises `busy` so control can stall the pipeline, and accepts MTHI/MTLO writes when idle.

---
 rtl/muldiv_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MTHI/MTLO moves.
// The result is visible 33 cycles after start. Busy covers the whole run, and new requests are ignored until it drops.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   opb;
  logic               is_div, is_signed, neg_a, neg_b, b_zero;

  logic               in_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_fix;

  assign in_signed = ~op[0];
  assign mag_a     = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b     = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign busy      = (state != IDLE);

  // acc holds {partial product, remaining multiplier} for multiply
  // and {remainder, quotient} for divide.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    sum      = '0;
    diff     = '0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (is_div) begin
          diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
          if (!diff[WIDTH])
            acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc_nx = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
          sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
          acc_nx = {sum, acc[WIDTH-1:1]};
        end
        if (cnt == 5'd31) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A zero divisor skips quotient negation, so LO stays all-ones and the
  // remainder (|a| re-signed) reproduces a.
  always_comb begin
    prod_fix = acc;
    res_hi   = acc[2*WIDTH-1:WIDTH];
    res_lo   = acc[WIDTH-1:0];
    if (!is_div) begin
      if (is_signed && (neg_a ^ neg_b)) prod_fix = ~acc + 1'b1;
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else begin
      if (is_signed && (neg_a ^ neg_b) && !b_zero)
        res_lo = ~acc[WIDTH-1:0] + 1'b1;
      if (is_signed && neg_a)
        res_hi = ~acc[2*WIDTH-1:WIDTH] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      b_zero    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= {{WIDTH{1'b0}}, mag_a};
            opb       <= mag_b;
            is_div    <= op[1];
            is_signed <= in_signed;
            neg_a     <= in_signed & a[WIDTH-1];
            neg_b     <= in_signed & b[WIDTH-1];
            b_zero    <= (b == '0);
            cnt       <= '0;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        RUN: cnt <= cnt + 5'd1;
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO are queued at issue and checked on each done pulse.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_issued = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [63:0] e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with nothing outstanding", hi, lo);
      end else begin
        e = exp_q.pop_front();
        check("result_hi", hi, e[63:32]);
        check("result_lo", lo, e[31:0]);
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic with_mtlo, input logic inject);
    int n;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = va; b = vb; mtlo = with_mtlo;
    exp_q.push_back({ehi, elo});
    n_issued++;
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (inject && n == 10) begin
        start = 1'b1; mthi = 1'b1; a = 32'hDEADBEEF; op = MULTU;
      end else begin
        start = 1'b0; mthi = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      end
      if (n == 5) begin
        check("hold_hi_run", hi, m_hi);
        check("hold_lo_run", lo, m_lo);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; mthi = 1'b0;
    check("busy_cycles", 32'(n), 32'd33);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    do_op(MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    do_op(MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0, 1'b0);
    do_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    do_op(DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    do_op(DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0, 1'b0);
    do_op(DIVU,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    do_op(MULTU, 32'd6,        32'd7,        32'h00000000, 32'h0000002A, 1'b0, 1'b1);

    // Both moves in idle
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; a = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0; a = 32'h0;
    check("mthi_hi", hi, 32'hA5A5A5A5);
    check("mtlo_lo", lo, 32'hA5A5A5A5);
    m_hi = 32'hA5A5A5A5; m_lo = 32'hA5A5A5A5;

    // start beats a simultaneous mtlo
    do_op(DIVU, 32'd7, 32'd2, 32'h00000001, 32'h00000003, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a MULTU
    @(posedge clk); #1;
    start = 1'b1; op = MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_done", 32'(done), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (40) @(posedge clk);
    #1;
    check("arst_no_result_hi", hi, 32'h0);

    do_op(MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(n_done), 32'(n_issued));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
